vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised single-clock VGA/LCD raster timing generator for CLK_25 designs. It produces sync, blank, active, pixel coordinates and frame/line strobes for any resolution, with configurable sync polarity and a pixel-clock enable. Both counters run on CLK_25; the vertical counter is not clocked from HS. It sits between the pixel clock and the frame-buffer/renderer logic and drives the DAC control pins.

## Interface
- H_ACT, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACT, 480, active lines per frame
- V_FRONT, 11, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 32, vertical back porch (lines)
- HS_POL, 0, asserted level of VGA_HS (0 = active-low)
- VS_POL, 0, asserted level of VGA_VS
- XW, 11, width of X/Y outputs; must hold H_ACT-1 and V_ACT-1

- CLK_25  in  1  pixel clock
- RST_N  in  1  reset, asynchronous, active-low
- EN  in  1  pixel advance enable; low freezes the generator
- VGA_HS  out  1  horizontal sync, polarity per HS_POL
- VGA_VS  out  1  vertical sync, polarity per VS_POL
- VGA_BLANK_N  out  1  high only in the active area
- VGA_SYNC_N  out  1  constant 0
- ACTIVE  out  1  same as VGA_BLANK_N, for internal consumers
- X  out  XW  active column, 0 outside the horizontal active area
- Y  out  XW  active row, 0 outside the vertical active area
- LINE_START  out  1  one-EN-cycle pulse on the first active pixel of each active line
- FRAME_START  out  1  one-EN-cycle pulse on pixel (0,0) of each frame

## Operation
- Derived constants: H_BLANK = H_FRONT+H_SYNC+H_BACK, H_TOTAL = H_BLANK+H_ACT, V_BLANK and V_TOTAL likewise.
- Line order is front porch, then sync, then back porch, then active. Frame order is the same.
- hc counts 0..H_TOTAL-1 and advances only when EN=1. It wraps to 0 on the cycle after H_TOTAL-1; there is no extra count at H_TOTAL.
- vc counts 0..V_TOTAL-1 and advances on the same EN cycle in which hc wraps. vc wraps to 0 after V_TOTAL-1.
- Decode of (hc, vc):
  - HS is asserted when H_FRONT ≤ hc < H_FRONT+H_SYNC.
  - VS is asserted when V_FRONT ≤ vc < V_FRONT+V_SYNC. VS edges therefore coincide with hc=0.
  - ACTIVE = (hc ≥ H_BLANK) && (vc ≥ V_BLANK).
  - X = hc−H_BLANK when hc ≥ H_BLANK, else 0. Y = vc−V_BLANK when vc ≥ V_BLANK, else 0. Both are truncated to XW bits.
  - LINE_START = ACTIVE && hc==H_BLANK. FRAME_START = LINE_START && vc==V_BLANK.
- Every output is registered. The decode is loaded into the output registers only on EN=1 cycles.
- Strobes: LINE_START and FRAME_START clear on any cycle with EN=0, so each pulse lasts exactly one CLK_25 cycle. All other outputs hold while EN=0.
- Reset values: hc=0, vc=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_BLANK_N=0, ACTIVE=0, X=0, Y=0, LINE_START=0, FRAME_START=0. VGA_SYNC_N is always 0.
- Reset asserted mid-frame forces the reset values immediately. The next frame after release starts at hc=0, vc=0.

## Timing
- Latency: the outputs show the decode of (hc, vc) one EN cycle after the counters hold that value. Base mode has no latency skew between any outputs.
- With EN tied high, the output state for pixel n (n = vc·H_TOTAL+hc) appears after rising edge n+1 following reset release.
- Line period is H_TOTAL EN cycles. Frame period is H_TOTAL·V_TOTAL EN cycles. Defaults give 800 and 420000.

## Configuration
- VGA_TIMING_PREFETCH_EN defined:
  - X, Y keep latency 1.
  - VGA_HS, VGA_VS, VGA_BLANK_N, ACTIVE, LINE_START and FRAME_START pass through one extra EN-gated register stage, giving latency 2.
  - A frame buffer with 1-cycle read latency addressed by X/Y then delivers data aligned with VGA_BLANK_N.
  - Reset values of the extra stage equal the reset values above.
- VGA_TIMING_PREFETCH_EN undefined: all outputs have latency 1, as in Timing.

## Test plan
- Defaults, EN=1, release reset:
  - VGA_HS falls after edge 17 and rises after edge 113.
  - The first VGA_BLANK_N high and FRAME_START pulse occur after edge 36161, with X=0 and Y=0.
- Defaults, one full line: VGA_BLANK_N is high for exactly 640 consecutive cycles. X runs 0..639 and returns to 0. LINE_START pulses once per active line, 480 per frame.
- H_ACT=4, H_FRONT=1, H_SYNC=1, H_BACK=2, V_ACT=3, V_FRONT=1, V_SYNC=1, V_BACK=1:
  - Line period is 8 cycles and frame period is 48.
  - VS is asserted for exactly 8 cycles.
  - FRAME_START recurs every 48 cycles.
- HS_POL=1, VS_POL=1: VGA_HS and VGA_VS idle low and pulse high, with the same edge positions as the first scenario.
- EN toggled 1,0,1,0…:
  - All edges occur at twice the cycle count.
  - Outputs hold while EN=0.
  - FRAME_START is high for exactly one CLK_25 cycle.
- Assert RST_N low at pixel (100,200) for 3 cycles:
  - Reset values appear asynchronously.
  - After release, timing matches the first scenario exactly.
  - With VGA_TIMING_PREFETCH_EN, VGA_BLANK_N lags X/Y by exactly one cycle.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen (master) and its consumers (slave).
// EN flows into the generator; every other signal is produced by it.
interface vga_timing_gen_if #(
    parameter int XW = 11
);
    logic          EN;
    logic          VGA_HS;
    logic          VGA_VS;
    logic          VGA_BLANK_N;
    logic          VGA_SYNC_N;
    logic          ACTIVE;
    logic [XW-1:0] X;
    logic [XW-1:0] Y;
    logic          LINE_START;
    logic          FRAME_START;

    modport master (
        input  EN,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, ACTIVE,
               X, Y, LINE_START, FRAME_START
    );

    modport slave (
        output EN,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, ACTIVE,
               X, Y, LINE_START, FRAME_START
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD raster timing generator on CLK_25 with pixel-advance enable.
// Optional VGA_TIMING_PREFETCH_EN: sync/blank/strobes lag X/Y by one extra EN cycle.
module vga_timing_gen #(
    parameter int H_ACT   = 640,
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int V_ACT   = 480,
    parameter int V_FRONT = 11,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 32,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int XW      = 11
) (
    input  logic              CLK_25,
    input  logic              RST_N,
    vga_timing_gen_if.master  bus
);
    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACT;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] HC_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_FRONT);
    localparam logic [HW-1:0] HS_END  = HW'(H_FRONT + H_SYNC);
    localparam logic [HW-1:0] HC_ACT  = HW'(H_BLANK);
    localparam logic [VW-1:0] VC_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_FRONT);
    localparam logic [VW-1:0] VS_END  = VW'(V_FRONT + V_SYNC);
    localparam logic [VW-1:0] VC_ACT  = VW'(V_BLANK);

    logic [HW-1:0] r_hc;
    logic [VW-1:0] r_vc;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_25 or negedge RST_N) begin
        if (!RST_N) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (bus.EN) begin
            if (r_hc == HC_LAST) begin
                r_hc <= '0;
                r_vc <= (r_vc == VC_LAST) ? '0 : r_vc + VW'(1);
            end else begin
                r_hc <= r_hc + HW'(1);
            end
        end
    end

    logic          w_h_act, w_v_act;
    logic          w_hs, w_vs, w_active, w_ls, w_fs;
    logic [XW-1:0] w_x, w_y;

    // NOTE: every signal is assigned on every pass through this block, so no latch can be inferred.
    always_comb begin
        w_h_act  = (r_hc >= HC_ACT);
        w_v_act  = (r_vc >= VC_ACT);
        w_hs     = ((r_hc >= HS_BEG) && (r_hc < HS_END)) ? HS_POL : ~HS_POL;
        w_vs     = ((r_vc >= VS_BEG) && (r_vc < VS_END)) ? VS_POL : ~VS_POL;
        w_active = w_h_act && w_v_act;
        w_x      = w_h_act ? XW'(r_hc - HC_ACT) : '0;
        w_y      = w_v_act ? XW'(r_vc - VC_ACT) : '0;
        w_ls     = w_active && (r_hc == HC_ACT);
        w_fs     = w_ls && (r_vc == VC_ACT);
    end

    logic w_o_hs, w_o_vs, w_o_active, w_o_ls, w_o_fs;

`ifdef VGA_TIMING_PREFETCH_EN
    logic r_p_hs, r_p_vs, r_p_active, r_p_ls, r_p_fs;

    // Inner strobes hold across EN=0 so the outer stage still sees them on the next EN cycle.
    always_ff @(posedge CLK_25 or negedge RST_N) begin
        if (!RST_N) begin
            r_p_hs     <= ~HS_POL;
            r_p_vs     <= ~VS_POL;
            r_p_active <= 1'b0;
            r_p_ls     <= 1'b0;
            r_p_fs     <= 1'b0;
        end else if (bus.EN) begin
            r_p_hs     <= w_hs;
            r_p_vs     <= w_vs;
            r_p_active <= w_active;
            r_p_ls     <= w_ls;
            r_p_fs     <= w_fs;
        end
    end

    assign w_o_hs     = r_p_hs;
    assign w_o_vs     = r_p_vs;
    assign w_o_active = r_p_active;
    assign w_o_ls     = r_p_ls;
    assign w_o_fs     = r_p_fs;
`else
    assign w_o_hs     = w_hs;
    assign w_o_vs     = w_vs;
    assign w_o_active = w_active;
    assign w_o_ls     = w_ls;
    assign w_o_fs     = w_fs;
`endif

    logic          r_hs, r_vs, r_active, r_ls, r_fs;
    logic [XW-1:0] r_x, r_y;

    always_ff @(posedge CLK_25 or negedge RST_N) begin
        if (!RST_N) begin
            r_hs     <= ~HS_POL;
            r_vs     <= ~VS_POL;
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_ls     <= 1'b0;
            r_fs     <= 1'b0;
        end else if (bus.EN) begin
            r_hs     <= w_o_hs;
            r_vs     <= w_o_vs;
            r_active <= w_o_active;
            r_x      <= w_x;
            r_y      <= w_y;
            r_ls     <= w_o_ls;
            r_fs     <= w_o_fs;
        end else begin
            // Strobes last one CLK_25 cycle even when EN is held low afterwards.
            r_ls <= 1'b0;
            r_fs <= 1'b0;
        end
    end

    assign bus.VGA_HS      = r_hs;
    assign bus.VGA_VS      = r_vs;
    assign bus.VGA_BLANK_N = r_active;
    assign bus.ACTIVE      = r_active;
    assign bus.VGA_SYNC_N  = 1'b0;
    assign bus.X           = r_x;
    assign bus.Y           = r_y;
    assign bus.LINE_START  = r_ls;
    assign bus.FRAME_START = r_fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default 640x480 timing, inverted polarity,
// and a tiny 8x6 raster exercised with EN toggling and a mid-frame reset.
module tb_vga_timing_gen;
`ifdef VGA_TIMING_PREFETCH_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NK       = 8;
    localparam int K_HS_ON  = 0;
    localparam int K_HS_OFF = 1;
    localparam int K_VS_ON  = 2;
    localparam int K_VS_OFF = 3;
    localparam int K_BL_ON  = 4;
    localparam int K_BL_OFF = 5;
    localparam int K_LS     = 6;
    localparam int K_FS     = 7;
    localparam int A_END    = 36900;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    string kname [NK] = '{"hs_assert", "hs_deassert", "vs_assert", "vs_deassert",
                          "blank_n_rise", "blank_n_fall", "line_start", "frame_start"};

    exp_t exp_q [3*NK][$];
    int   xq [$];
    int   compared   = 0;
    int   mismatched = 0;

    logic clk    = 1'b0;
    logic rst_ab = 1'b0;
    logic rst_c  = 1'b0;
    int   cyc_ab = 0;
    int   cyc_c  = 0;
    logic prev_hs [3];
    logic prev_vs [3];
    logic prev_bl [3];
    logic prev_ls [3];
    logic prev_fs [3];

    vga_timing_gen_if #(.XW(11)) bus_a ();
    vga_timing_gen_if #(.XW(11)) bus_b ();
    vga_timing_gen_if #(.XW(4))  bus_c ();

    vga_timing_gen u_a (.CLK_25(clk), .RST_N(rst_ab), .bus(bus_a));
    vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1)) u_b (.CLK_25(clk), .RST_N(rst_ab), .bus(bus_b));
    vga_timing_gen #(
        .H_ACT(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(2),
        .V_ACT(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .XW(4)
    ) u_c (.CLK_25(clk), .RST_N(rst_c), .bus(bus_c));

    always #5 clk = ~clk;

    always @(posedge clk) cyc_ab <= rst_ab ? cyc_ab + 1 : 0;
    always @(posedge clk) cyc_c  <= rst_c  ? cyc_c  + 1 : 0;

    task automatic check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        compared++;
        mismatched++;
        $display("FAIL %s", name);
    endtask

    function automatic int edge_of(int pix, bit tog);
        return tog ? 2 * (pix + LAT) - 1 : pix + LAT;
    endfunction

    task automatic push(int d, int k, int cyc, int val);
        exp_t e;
        e.cyc = cyc;
        e.val = val;
        exp_q[d*NK + k].push_back(e);
    endtask

    task automatic emit(int d, int k, int cyc, int xyv);
        exp_t e;
        if (exp_q[d*NK + k].size() == 0) begin
            fail($sformatf("dut%0d unexpected %s at cycle %0d", d, kname[k], cyc));
        end else begin
            e = exp_q[d*NK + k].pop_front();
            check($sformatf("dut%0d_%s_cycle", d, kname[k]), cyc, e.cyc);
            if (e.val >= 0) check($sformatf("dut%0d_%s_xy", d, kname[k]), xyv, e.val);
        end
    endtask

    // Monitor: turns output changes into events and matches them against the queues.
    task automatic observe(int d, logic rn, int cyc, logic hs_on, logic vs_on, logic bl,
                           logic act, logic sn, int x, int y, logic ls, logic fs);
        int xyv;
        if (!rn) begin
            prev_hs[d] <= 1'b0; prev_vs[d] <= 1'b0; prev_bl[d] <= 1'b0;
            prev_ls[d] <= 1'b0; prev_fs[d] <= 1'b0;
            return;
        end
        xyv = (y << 12) | x;
        check($sformatf("dut%0d_active_eq_blank_n", d), act, bl);
        check($sformatf("dut%0d_sync_n", d), sn, 0);
        if (hs_on != prev_hs[d]) emit(d, hs_on ? K_HS_ON : K_HS_OFF, cyc, xyv);
        if (vs_on != prev_vs[d]) emit(d, vs_on ? K_VS_ON : K_VS_OFF, cyc, xyv);
        if (bl != prev_bl[d])    emit(d, bl ? K_BL_ON : K_BL_OFF, cyc, xyv);
        if (prev_ls[d]) check($sformatf("dut%0d_line_start_width", d), ls, 0);
        if (prev_fs[d]) check($sformatf("dut%0d_frame_start_width", d), fs, 0);
        if (ls && !prev_ls[d]) emit(d, K_LS, cyc, xyv);
        if (fs && !prev_fs[d]) emit(d, K_FS, cyc, xyv);
        if (d == 0 && act) begin
            if (xq.size() == 0) fail($sformatf("dut0 unexpected active pixel at cycle %0d", cyc));
            else check("dut0_x_run", x, xq.pop_front());
        end
        prev_hs[d] <= hs_on; prev_vs[d] <= vs_on; prev_bl[d] <= bl;
        prev_ls[d] <= ls;    prev_fs[d] <= fs;
    endtask

    always @(negedge clk)
        observe(0, rst_ab, cyc_ab, !bus_a.VGA_HS, !bus_a.VGA_VS, bus_a.VGA_BLANK_N, bus_a.ACTIVE,
                bus_a.VGA_SYNC_N, int'(bus_a.X), int'(bus_a.Y), bus_a.LINE_START, bus_a.FRAME_START);
    always @(negedge clk)
        observe(1, rst_ab, cyc_ab, bus_b.VGA_HS, bus_b.VGA_VS, bus_b.VGA_BLANK_N, bus_b.ACTIVE,
                bus_b.VGA_SYNC_N, int'(bus_b.X), int'(bus_b.Y), bus_b.LINE_START, bus_b.FRAME_START);
    always @(negedge clk)
        observe(2, rst_c, cyc_c, !bus_c.VGA_HS, !bus_c.VGA_VS, bus_c.VGA_BLANK_N, bus_c.ACTIVE,
                bus_c.VGA_SYNC_N, int'(bus_c.X), int'(bus_c.Y), bus_c.LINE_START, bus_c.FRAME_START);

    task automatic expect_drained(int d);
        for (int k = 0; k < NK; k++) begin
            check($sformatf("dut%0d_%s_left_over", d, kname[k]), exp_q[d*NK + k].size(), 0);
            exp_q[d*NK + k].delete();
        end
        if (d == 0) begin
            check("dut0_x_run_left_over", xq.size(), 0);
            xq.delete();
        end
    endtask

    task automatic check_rst(string tag, logic hs, logic vs, logic bl, logic act, logic sn,
                             logic ls, logic fs, int x, int y, bit hp, bit vp);
        check({tag, "_rst_hs"}, hs, int'(!hp));
        check({tag, "_rst_vs"}, vs, int'(!vp));
        check({tag, "_rst_flags"}, {bl, act, sn, ls, fs}, 0);
        check({tag, "_rst_x"}, x, 0);
        check({tag, "_rst_y"}, y, 0);
    endtask

    // Default 800x525 raster: HS at pixels 16..111 of every line, VS on lines 11..12,
    // first active pixel at line 45, column 160 (pixel 36160).
    task automatic add_a(int k, int pix, int val);
        if (pix + LAT <= A_END) begin
            push(0, k, pix + LAT, val);
            push(1, k, pix + LAT, val);
        end
    endtask

    task automatic push_a();
        for (int l = 0; l <= 46; l++) begin
            add_a(K_HS_ON,  l*800 + 16,  -1);
            add_a(K_HS_OFF, l*800 + 112, -1);
        end
        add_a(K_VS_ON,  11*800, -1);
        add_a(K_VS_OFF, 13*800, -1);
        add_a(K_BL_ON,  36160, LAT - 1);
        add_a(K_LS,     36160, LAT - 1);
        add_a(K_FS,     36160, LAT - 1);
        add_a(K_BL_OFF, 36800, 1 << 12);
        for (int k = 0; k < 640; k++) xq.push_back((k + LAT - 1 >= 640) ? 0 : k + LAT - 1);
    endtask

    // Tiny 8x6 raster: HS at hc=1, VS on vc=1, active hc 4..7 of rows vc 3..5.
    task automatic add_c(int k, int pix, int val, int limit, bit tog);
        if (pix < limit) push(2, k, edge_of(pix, tog), val);
    endtask

    task automatic push_c(int limit, bit tog);
        int l;
        for (int p0 = 0; p0 < limit; p0 += 8) begin
            l = (p0 / 8) % 6;
            add_c(K_HS_ON,  p0 + 1, -1, limit, tog);
            add_c(K_HS_OFF, p0 + 2, -1, limit, tog);
            if (l == 1) add_c(K_VS_ON,  p0, -1, limit, tog);
            if (l == 2) add_c(K_VS_OFF, p0, -1, limit, tog);
            if (l >= 3) begin
                add_c(K_BL_ON, p0 + 4, ((l - 3) << 12) | (LAT - 1), limit, tog);
                add_c(K_LS,    p0 + 4, ((l - 3) << 12) | (LAT - 1), limit, tog);
                if (l == 3) add_c(K_FS, p0 + 4, LAT - 1, limit, tog);
                add_c(K_BL_OFF, p0 + 8, (l < 5) ? ((l - 2) << 12) : 0, limit, tog);
            end
        end
    endtask

    task automatic run_c(int limit, bit tog);
        int last;
        int guard;
        last  = edge_of(limit - 1, tog);
        guard = 0;
        while (cyc_c < last && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (cyc_c >= last) bus_c.EN = 1'b0;
            else if (tog)      bus_c.EN = ~bus_c.EN;
        end
        bus_c.EN = 1'b0;
        if (guard >= 5000) fail("dut2 run timeout");
        repeat (4) @(negedge clk);
        expect_drained(2);
    endtask

    task automatic reset_c();
        @(negedge clk);
        rst_c = 1'b0;
        repeat (3) @(negedge clk);
        check_rst("c", bus_c.VGA_HS, bus_c.VGA_VS, bus_c.VGA_BLANK_N, bus_c.ACTIVE, bus_c.VGA_SYNC_N,
                  bus_c.LINE_START, bus_c.FRAME_START, int'(bus_c.X), int'(bus_c.Y), 1'b0, 1'b0);
    endtask

    initial begin
        int guard;
        bus_a.EN = 1'b0;
        bus_b.EN = 1'b0;
        bus_c.EN = 1'b0;
        repeat (3) @(negedge clk);
        check_rst("a", bus_a.VGA_HS, bus_a.VGA_VS, bus_a.VGA_BLANK_N, bus_a.ACTIVE, bus_a.VGA_SYNC_N,
                  bus_a.LINE_START, bus_a.FRAME_START, int'(bus_a.X), int'(bus_a.Y), 1'b0, 1'b0);
        check_rst("b", bus_b.VGA_HS, bus_b.VGA_VS, bus_b.VGA_BLANK_N, bus_b.ACTIVE, bus_b.VGA_SYNC_N,
                  bus_b.LINE_START, bus_b.FRAME_START, int'(bus_b.X), int'(bus_b.Y), 1'b1, 1'b1);

        // Default raster, EN high, through the first active line.
        push_a();
        bus_a.EN = 1'b1;
        bus_b.EN = 1'b1;
        @(negedge clk);
        rst_ab = 1'b1;
        guard = 0;
        while (cyc_ab < A_END && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        bus_a.EN = 1'b0;
        bus_b.EN = 1'b0;
        if (guard >= 40000) fail("dut0 run timeout");
        repeat (4) @(negedge clk);
        expect_drained(0);
        expect_drained(1);

        // Tiny raster: two frames with EN high, then two frames with EN toggling.
        reset_c();
        push_c(96, 1'b0);
        bus_c.EN = 1'b1;
        rst_c = 1'b1;
        run_c(96, 1'b0);

        reset_c();
        push_c(96, 1'b1);
        bus_c.EN = 1'b1;
        rst_c = 1'b1;
        run_c(96, 1'b1);

        // Mid-frame reset at pixel (hc=5, vc=4), then a full frame from the top.
        reset_c();
        push_c(38, 1'b0);
        bus_c.EN = 1'b1;
        rst_c = 1'b1;
        guard = 0;
        while (cyc_c < edge_of(37, 1'b0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) fail("dut2 pre-reset timeout");
        check("c_pre_reset_x", int'(bus_c.X), LAT);
        #2;
        rst_c = 1'b0;
        #1;
        check_rst("c_async", bus_c.VGA_HS, bus_c.VGA_VS, bus_c.VGA_BLANK_N, bus_c.ACTIVE,
                  bus_c.VGA_SYNC_N, bus_c.LINE_START, bus_c.FRAME_START,
                  int'(bus_c.X), int'(bus_c.Y), 1'b0, 1'b0);
        expect_drained(2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        push_c(48, 1'b0);
        rst_c = 1'b1;
        run_c(48, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
